// File: rtl/multi_ch_debouncer.sv
// N-channel switch/button debouncer: 2-flop synchroniser, per-channel qualify FSM,
// registered rise/fall pulses, all sampled on one shared prescaler tick.
module multi_ch_debouncer #(
    parameter int   N_CH         = 4,
    parameter int   TICK_DIV     = 500000,
    parameter int   STABLE_TICKS = 4,
    parameter logic INIT_VAL     = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] db_out,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] busy,
    output logic            tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

    typedef enum logic {IDLE, CHECK} state_t;

    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic            tick_q, tick_d;
    logic [N_CH-1:0] sync1_q, sync2_q;

    always_comb begin
        tick_d = (pcnt_q == PCNT_LAST);
        pcnt_d = tick_d ? '0 : pcnt_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q  <= '0;
            tick_q  <= 1'b0;
            sync1_q <= {N_CH{INIT_VAL}};
            sync2_q <= {N_CH{INIT_VAL}};
        end else begin
            pcnt_q  <= pcnt_d;
            tick_q  <= tick_d;
            sync1_q <= in;
            sync2_q <= sync1_q;
        end
    end

    assign tick = tick_q;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            state_t        state_q, state_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic          db_q, db_d;
            logic          rise_q, rise_d;
            logic          fall_q, fall_d;
            logic          busy_q;
            logic          s;

            assign s = sync2_q[gi];

            // Returning to the committed level wins over a coincident tick.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                db_d    = db_q;
                rise_d  = 1'b0;
                fall_d  = 1'b0;
                if (state_q == IDLE) begin
                    if (s != db_q) begin
                        state_d = CHECK;
                        cnt_d   = '0;
                    end
                end else begin
                    if (s == db_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (tick_q) begin
                        if (cnt_q == CNT_LAST) begin
                            db_d    = s;
                            rise_d  = s;
                            fall_d  = ~s;
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    db_q    <= INIT_VAL;
                    rise_q  <= 1'b0;
                    fall_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    db_q    <= db_d;
                    rise_q  <= rise_d;
                    fall_q  <= fall_d;
                    busy_q  <= (state_d == CHECK);
                end
            end

            assign db_out[gi] = db_q;
            assign rise[gi]   = rise_q;
            assign fall[gi]   = fall_q;
            assign busy[gi]   = busy_q;
        end
    endgenerate

endmodule
